i2c_byte_sequencer: RTL and testbench
=====================================

Name: i2c_byte_sequencer

Overview:
- Byte-level I2C master sequencer for the FMC424 I2C controller.
- Accepts one command per transaction: optional START/repeated-START, one 8-bit write or read with its ACK bit, optional STOP.
- Generates SCL/SDA as open-drain pull-low enables for the top-level IO buffers, timed by an internal quarter-bit-period divider from the 50 MHz clock, and returns read data and ACK status.
- Sits between the register/command front end and the SCL/SDA IOBUFs; it replaces the free-running SCL divider wherever transactions must be sequenced.

Parameters:
- QTR_DIV, 125, CLK cycles per quarter bit period (50 MHz / (4*125) = 100 kHz SCL); legal range 2..1023.

Ports:
- CLK  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_start  in  1  issue START (repeated START if the bus is already owned) before the byte.
- cmd_stop  in  1  issue STOP after the ACK bit.
- cmd_read  in  1  1 = read byte from slave, 0 = write cmd_wdata.
- cmd_wdata  in  8  write byte, MSB first.
- cmd_nack_out  in  1  read only: ACK bit to drive (1 = NACK/release, 0 = ACK/pull low).
- rsp_valid  out  1  one-cycle pulse when the command completes.
- rsp_rdata  out  8  read byte; holds until the next rsp_valid.
- rsp_nack  out  1  write: sampled slave ACK bit (1 = NACK); read: echoes cmd_nack_out.
- busy  out  1  high from command accept until return to IDLE.
- scl_i  in  1  SCL pin input, used for clock stretching.
- sda_i  in  1  SDA pin input.
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- sda_oe  out  1  1 = pull SDA low, 0 = release.

Behaviour:
- Reset (rst=0 at posedge CLK):
  - State IDLE; scl_oe=0, sda_oe=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_nack=0, divider=0.
  - Applies mid-transaction as well: the bus is released on the next edge, and no STOP is generated.
- Handshake:
  - A command is accepted on a cycle with cmd_valid & cmd_ready. All cmd_* fields are registered at accept.
  - cmd_ready drops the following cycle.
- Quarter timing:
  - The divider counts 0..QTR_DIV-1 and only counts outside IDLE; it is cleared at accept.
  - A "tick" occurs when the count equals QTR_DIV-1. Each phase has quarters q0..q3, and q advances on each tick.
- Clock stretching: in q2 of the START, BIT, ACK and STOP phases, the divider holds while scl_i=0. The slave stretches the high period; the master never shortens it.
- States and pin drive (quarters listed as q0/q1/q2/q3):
  - IDLE: scl_oe=0, sda_oe=0.
  - On accept: go to START if cmd_start, else BIT.
  - START: scl_oe = 1/0/0/0; sda_oe = 0/0/1/1. Then BIT.
  - BIT (8 iterations, bit index 7 down to 0):
    - scl_oe = 1/1/0/0.
    - sda_oe = ~bit for all four quarters on a write; 0 on a read.
    - Read: sda_i is sampled on the q2 tick and shifted in LSB-first-into-shift, so the final byte is MSB-first.
    - After bit 0, go to ACK.
  - ACK: scl_oe = 1/1/0/0.
    - Write: sda_oe=0; sda_i is sampled on the q2 tick into rsp_nack.
    - Read: sda_oe = ~cmd_nack_out.
    - Then STOP if cmd_stop, else DONE.
  - STOP: scl_oe = 1/0/0/0; sda_oe = 1/1/1/0. Then DONE.
  - DONE: one cycle; rsp_valid=1 and rsp_rdata/rsp_nack updated. Then IDLE.
- Bus held between commands: without STOP, on return to IDLE the sequencer keeps scl_oe=1 and sda_oe at its last ACK value until the next command, so the bus stays owned. A following cmd_start produces a repeated START.
- NACK on a write does not abort; the STOP is still issued if requested. Policy belongs to the front end.
- Latency with no stretching, in cycles from the accept edge to the rsp_valid cycle: 4*QTR_DIV*(9 + cmd_start + cmd_stop) + 1.
- cmd_valid asserted while busy is ignored and not queued.
- Each output changes at most once per CLK edge. No combinational path from inputs to scl_oe/sda_oe.

Test Plan:
- Reset: drive rst=0 mid-BIT on a write of 0xA5 -> next edge scl_oe=0, sda_oe=0, cmd_ready=1, rsp_valid stays 0.
- Write with start and stop, QTR_DIV=4, slave ACKs: write 0xA5 -> 177 cycles from accept to rsp_valid. Checks:
  - START edge: SDA falls while SCL is released.
  - Bits on SDA are 1,0,1,0,0,1,0,1.
  - rsp_nack=0.
  - STOP edge: SDA rises while SCL is released.
  - Bus idle afterwards.
- Write NACK: slave leaves SDA released at ACK -> rsp_nack=1; STOP is still generated when cmd_stop=1.
- Read with repeated START: write 0x90 with no stop, then read with cmd_start=1, cmd_stop=1, cmd_nack_out=1, slave returns 0x3C. Checks:
  - SCL stays low between the two commands.
  - Repeated START occurs.
  - rsp_rdata=0x3C.
  - SDA is released during the ACK bit.
- Clock stretch: slave holds scl_i low for 37 cycles in q2 of bit 4 -> total latency grows by exactly 37 cycles and the data is unchanged.
- Back-to-back: cmd_valid held high across completion -> second command accepted on the first cycle cmd_ready=1 after DONE; cmd_valid during busy produces no extra transaction.

Source files
------------

// File: rtl/i2c_byte_sequencer.sv
// Byte-level I2C master sequencer: one optional START, one 8-bit write or read with
// its ACK bit, and one optional STOP per command, driving open-drain pull-low enables.
module i2c_byte_sequencer #(
  parameter int QTR_DIV = 125
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_read,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_nack_out,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [9:0] DIV_LAST = 10'(QTR_DIV - 1);

  state_t      state_q, state_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [9:0]  div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_q, stop_d;
  logic        read_q, read_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        nack_out_q, nack_out_d;
  logic [7:0]  shift_q, shift_d;
  logic        ack_q, ack_d;
  logic        hold_bus_q, hold_bus_d;
  logic        hold_sda_q, hold_sda_d;
  logic        cmd_ready_d, busy_d, rsp_valid_d, rsp_nack_d;
  logic [7:0]  rsp_rdata_d;
  logic        scl_oe_d, sda_oe_d;
  logic        tick, stall;

  // Pin drive as a pure function of the (next) sequencer registers, so the pins are
  // registered alongside the state and never see a decode glitch or an input path.
  function automatic logic [1:0] pin_drive(
    input state_t     st,
    input logic [1:0] q,
    input logic [2:0] b,
    input logic       rd,
    input logic [7:0] wd,
    input logic       nk,
    input logic       hb,
    input logic       hs
  );
    logic scl, sda;
    scl = 1'b0;
    sda = 1'b0;
    case (st)
      S_START: begin scl = (q == 2'd0); sda = q[1];           end
      S_BIT:   begin scl = ~q[1];       sda = ~rd & ~wd[b];   end
      S_ACK:   begin scl = ~q[1];       sda = rd & ~nk;       end
      S_STOP:  begin scl = (q == 2'd0); sda = (q != 2'd3);    end
      default: begin scl = hb;          sda = hb & hs;        end
    endcase
    return {scl, sda};
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    state_d     = state_q;
    qtr_d       = qtr_q;
    div_d       = div_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    read_d      = read_q;
    wdata_d     = wdata_q;
    nack_out_d  = nack_out_q;
    shift_d     = shift_q;
    ack_d       = ack_q;
    hold_bus_d  = hold_bus_q;
    hold_sda_d  = hold_sda_q;
    rsp_rdata_d = rsp_rdata;
    rsp_nack_d  = rsp_nack;
    tick        = 1'b0;
    stall       = 1'b0;

    // The slave may stretch the SCL high quarter; the divider simply waits for it.
    if (state_q inside {S_START, S_BIT, S_ACK, S_STOP}) begin
      stall = (qtr_q == 2'd2) && !scl_i;
      if (!stall) begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          tick  = 1'b1;
        end else begin
          div_d = div_q + 10'd1;
        end
      end
    end
    if (tick) qtr_d = qtr_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          stop_d     = cmd_stop;
          read_d     = cmd_read;
          wdata_d    = cmd_wdata;
          nack_out_d = cmd_nack_out;
          shift_d    = '0;
          div_d      = '0;
          qtr_d      = '0;
          bit_d      = 3'd7;
          state_d    = cmd_start ? S_START : S_BIT;
        end
      end
      S_START: begin
        if (tick && qtr_q == 2'd3) state_d = S_BIT;
      end
      S_BIT: begin
        if (tick) begin
          if (qtr_q == 2'd2 && read_q) shift_d = {shift_q[6:0], sda_i};
          if (qtr_q == 2'd3) begin
            if (bit_q == 3'd0) state_d = S_ACK;
            else               bit_d   = bit_q - 3'd1;
          end
        end
      end
      S_ACK: begin
        if (tick) begin
          if (qtr_q == 2'd2 && !read_q) ack_d = sda_i;
          if (qtr_q == 2'd3) begin
            if (stop_q) begin
              state_d = S_STOP;
            end else begin
              // Keep the bus owned: SCL low and SDA as it was during the ACK bit.
              state_d    = S_DONE;
              hold_bus_d = 1'b1;
              hold_sda_d = read_q & ~nack_out_q;
            end
          end
        end
      end
      S_STOP: begin
        if (tick && qtr_q == 2'd3) begin
          state_d    = S_DONE;
          hold_bus_d = 1'b0;
          hold_sda_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        div_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = (state_d == S_DONE);
    if (rsp_valid_d) begin
      rsp_rdata_d = read_q ? shift_d : 8'h00;
      rsp_nack_d  = read_q ? nack_out_q : ack_d;
    end
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = ~cmd_ready_d;
    {scl_oe_d, sda_oe_d} = pin_drive(state_d, qtr_d, bit_d, read_d, wdata_d,
                                     nack_out_d, hold_bus_d, hold_sda_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order within the block.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      qtr_q      <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      read_q     <= 1'b0;
      wdata_q    <= '0;
      nack_out_q <= 1'b0;
      shift_q    <= '0;
      ack_q      <= 1'b0;
      hold_bus_q <= 1'b0;
      hold_sda_q <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_nack   <= 1'b0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
    end else begin
      state_q    <= state_d;
      qtr_q      <= qtr_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      read_q     <= read_d;
      wdata_q    <= wdata_d;
      nack_out_q <= nack_out_d;
      shift_q    <= shift_d;
      ack_q      <= ack_d;
      hold_bus_q <= hold_bus_d;
      hold_sda_q <= hold_sda_d;
      cmd_ready  <= cmd_ready_d;
      busy       <= busy_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_nack   <= rsp_nack_d;
      scl_oe     <= scl_oe_d;
      sda_oe     <= sda_oe_d;
    end
  end

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Directed bench for i2c_byte_sequencer (QTR_DIV=4) with a small bus-level slave
// model that decodes START/STOP, captures written bytes and serves read data.
module tb_i2c_byte_sequencer;

  logic       CLK = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0, cmd_read = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_nack_out = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_nack, busy, scl_oe, sda_oe;
  logic [7:0] rsp_rdata;
  logic       scl_i, sda_i;

  // Bus lines: open-drain wired-AND of master, slave data drive and slave stretch.
  logic slave_low = 1'b0;
  logic stretch   = 1'b0;
  assign scl_i = !(scl_oe || stretch);
  assign sda_i = !(sda_oe || slave_low);

  i2c_byte_sequencer #(.QTR_DIV(4)) dut (
    .CLK(CLK), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start),
    .cmd_stop(cmd_stop), .cmd_read(cmd_read), .cmd_wdata(cmd_wdata),
    .cmd_nack_out(cmd_nack_out),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
    .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor and slave state, all updated on the falling edge.
  int         cyc = 0;
  int         acc_cnt = 0, rsp_cnt = 0, acc_cyc = 0, rsp_cyc = 0, lat = 0;
  logic [7:0] last_rdata = 8'h00;
  logic       last_nack = 1'b0;
  int         hold_viol = 0, rdy_viol = 0;
  bit         hold_win = 1'b0;
  int         bit_n = 99, start_cnt = 0, stop_cnt = 0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, ack_line = 1'b0;
  logic [7:0] slave_rx = 8'h00;
  bit         slave_ack = 1'b1, slave_tx = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       prev_scl_oe = 1'b0;
  int         rel_cnt = 0, stretch_cnt = 0, stretch_at = 0, stretch_hits = 0;
  bit         stretch_arm = 1'b0;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    logic scl_l, sda_l;
    scl_l = !scl_oe;
    sda_l = sda_i;

    if (rst && cmd_valid && cmd_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
      rel_cnt = 0;
    end
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc    = cyc;
      lat        = cyc - acc_cyc;
      last_rdata = rsp_rdata;
      last_nack  = rsp_nack;
    end
    if (hold_win && !scl_oe) hold_viol++;
    if (busy == cmd_ready) rdy_viol++;

    if (stretch_cnt > 0) begin
      stretch_cnt--;
      if (stretch_cnt == 0) stretch = 1'b0;
    end
    if (prev_scl_oe && !scl_oe) begin
      rel_cnt++;
      if (stretch_arm && rel_cnt == stretch_at) begin
        stretch     = 1'b1;
        stretch_cnt = 37;
        stretch_arm = 1'b0;
        stretch_hits++;
      end
    end
    prev_scl_oe = scl_oe;

    if (!rst) begin
      bit_n     = 99;
      slave_low = 1'b0;
    end else if (prev_scl && scl_l && prev_sda && !sda_l) begin
      start_cnt++;
      bit_n    = 0;
      slave_rx = 8'h00;
    end else if (prev_scl && scl_l && !prev_sda && sda_l) begin
      stop_cnt++;
      bit_n     = 99;
      slave_low = 1'b0;
    end else if (!prev_scl && scl_l) begin
      bit_n++;
      if (bit_n <= 8)      slave_rx = {slave_rx[6:0], sda_l};
      else if (bit_n == 9) ack_line = sda_l;
    end else if (prev_scl && !scl_l) begin
      if (bit_n == 8)                slave_low = slave_ack && !slave_tx;
      else if (bit_n < 8 && slave_tx) slave_low = !tx_byte[3'(7 - bit_n)];
      else                           slave_low = 1'b0;
    end
    prev_scl = scl_l;
    prev_sda = sda_l;
  end

  task automatic send(input logic s, input logic p, input logic r,
                      input logic [7:0] wd, input logic nk);
    int n0, w;
    @(posedge CLK); #1;
    n0 = acc_cnt;
    cmd_start = s; cmd_stop = p; cmd_read = r; cmd_wdata = wd; cmd_nack_out = nk;
    cmd_valid = 1'b1;
    w = 0;
    while (acc_cnt == n0 && w < 2000) begin
      @(posedge CLK); #1;
      w++;
    end
    cmd_valid = 1'b0;
    check("accept", 32'(acc_cnt != n0), 32'd1);
  endtask

  task automatic wait_rsp(input string tag, input int r0);
    int w;
    w = 0;
    while (rsp_cnt == r0 && w < 4000) begin
      @(posedge CLK); #1;
      w++;
    end
    check(tag, 32'(rsp_cnt != r0), 32'd1);
  endtask

  initial begin
    int r0, a0, s0, p0, gap;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_nack", rsp_nack, 0);
    rst = 1'b1;
    repeat (2) @(posedge CLK);

    // Write 0xA5 with START and STOP, slave ACKs.
    slave_ack = 1'b1; slave_tx = 1'b0;
    s0 = start_cnt; p0 = stop_cnt; r0 = rsp_cnt;
    send(1, 1, 0, 8'hA5, 0);
    wait_rsp("wr_rsp", r0);
    check("wr_latency", lat, 177);
    check("wr_start_seen", start_cnt - s0, 1);
    check("wr_byte_on_sda", slave_rx, 8'hA5);
    check("wr_nack", last_nack, 0);
    check("wr_stop_seen", stop_cnt - p0, 1);
    check("wr_idle_scl", scl_oe, 0);
    check("wr_idle_sda", sda_oe, 0);
    check("wr_idle_ready", cmd_ready, 1);

    // Write with slave NACK still issues the STOP.
    slave_ack = 1'b0;
    p0 = stop_cnt; r0 = rsp_cnt;
    send(1, 1, 0, 8'h5A, 0);
    wait_rsp("nack_rsp", r0);
    check("nack_flag", last_nack, 1);
    check("nack_byte", slave_rx, 8'h5A);
    check("nack_stop_seen", stop_cnt - p0, 1);
    check("nack_latency", lat, 177);

    // Write 0x90 without STOP, then read with repeated START.
    slave_ack = 1'b1;
    r0 = rsp_cnt;
    send(1, 0, 0, 8'h90, 0);
    wait_rsp("rs_wr_rsp", r0);
    check("rs_wr_latency", lat, 161);
    check("rs_wr_nack", last_nack, 0);
    check("rs_hold_scl", scl_oe, 1);
    check("rs_hold_sda", sda_oe, 0);
    hold_viol = 0;
    hold_win  = 1'b1;
    repeat (6) @(posedge CLK);
    slave_tx = 1'b1; tx_byte = 8'h3C;
    s0 = start_cnt; p0 = stop_cnt; r0 = rsp_cnt;
    send(1, 1, 1, 8'h00, 1);
    hold_win = 1'b0;
    wait_rsp("rs_rd_rsp", r0);
    check("rs_scl_held_low", hold_viol, 0);
    check("rs_restart_seen", start_cnt - s0, 1);
    check("rs_rdata", last_rdata, 8'h3C);
    check("rs_rsp_nack", last_nack, 1);
    check("rs_ack_released", ack_line, 1);
    check("rs_stop_seen", stop_cnt - p0, 1);
    check("rs_rd_latency", lat, 177);

    // Clock stretch of 37 cycles in q2 of bit 4 during a read that ACKs.
    tx_byte = 8'hA7; stretch_at = 5; stretch_arm = 1'b1;
    s0 = stretch_hits; r0 = rsp_cnt;
    send(1, 1, 1, 8'h00, 0);
    wait_rsp("st_rsp", r0);
    check("st_fired", stretch_hits - s0, 1);
    check("st_latency", lat, 214);
    check("st_rdata", last_rdata, 8'hA7);
    check("st_rsp_nack", last_nack, 0);
    check("st_ack_driven", ack_line, 0);
    slave_tx = 1'b0;

    // Back-to-back: cmd_valid held high across completion.
    a0 = acc_cnt; r0 = rsp_cnt; gap = -1;
    @(posedge CLK); #1;
    cmd_start = 1'b1; cmd_stop = 1'b1; cmd_read = 1'b0; cmd_wdata = 8'h33; cmd_nack_out = 1'b0;
    cmd_valid = 1'b1;
    for (int w = 0; w < 4000 && acc_cnt < a0 + 2; w++) begin
      @(posedge CLK); #1;
    end
    cmd_valid = 1'b0;
    gap = acc_cyc - rsp_cyc;
    check("b2b_gap", gap, 1);
    wait_rsp("b2b_rsp", r0 + 1);
    check("b2b_latency", lat, 177);
    repeat (100) @(posedge CLK);
    #1;
    check("b2b_accepts", acc_cnt - a0, 2);
    check("b2b_rsps", rsp_cnt - r0, 2);
    check("b2b_byte", slave_rx, 8'h33);
    check("ready_busy_exclusive", rdy_viol, 0);

    // Reset mid-BIT (bit 6, low half) of a write of 0xA5.
    send(1, 1, 0, 8'hA5, 0);
    repeat (37) @(posedge CLK);
    #1;
    check("mid_scl_oe", scl_oe, 1);
    check("mid_sda_oe", sda_oe, 1);
    rst = 1'b0;
    r0  = rsp_cnt;
    @(posedge CLK); #1;
    check("mrst_scl_oe", scl_oe, 0);
    check("mrst_sda_oe", sda_oe, 0);
    check("mrst_ready", cmd_ready, 1);
    check("mrst_busy", busy, 0);
    check("mrst_rsp_valid", rsp_valid, 0);
    rst = 1'b1;
    repeat (300) @(posedge CLK);
    #1;
    check("mrst_no_rsp", rsp_cnt - r0, 0);
    check("mrst_bus_idle", {scl_oe, sda_oe}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
